// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, default 640x480 constants and total-length helpers.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int MAX_TOTAL     = 1024;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_sync_t;

    // Idle/reset level: syncs deasserted, blank reports the (0,0) visible pixel.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

    function automatic int h_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register with asynchronous active-low reset to a given value.
module sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             en,
    input  logic [WIDTH-1:0] source,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_bypass
        assign delayed = source;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk_sys or negedge rst_b) begin
            if (!rst_b) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
                stage[0] <= source;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign delayed = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable/clock, DrawX/DrawY counters, sync/blank decodes,
// frame-level pulses and a pixel-aligned delayed copy of sync/blank.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int PIX_DIV    = 2,
    parameter int PIPE_DELAY = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_ce,
    output logic       VGA_Clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam int H_TOT    = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOT    = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int DIV_W    = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);
    localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);

    if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIX_DIV < 2 || (PIX_DIV % 2) != 0) begin : g_div_check
        $error("vga_timing_gen: PIX_DIV must be even and at least 2");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_pipe_check
        $error("vga_timing_gen: PIPE_DELAY must be within 0..4");
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    vga_sync_t        sync_next;
    vga_sync_t        sync_q;
    vga_sync_t        sync_dly;

    assign pixel_ce = (div == DIV_LAST);

    // Decodes use the next counter values so the registered flags move with DrawX/DrawY.
    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        x_next   = DrawX;
        y_next   = DrawY;
        if (pixel_ce) begin
            if (DrawX == H_LAST) begin
                x_next = '0;
                y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
            end else begin
                x_next = DrawX + 10'd1;
            end
        end
        sync_next.blank = (int'(x_next) < H_VISIBLE) && (int'(y_next) < V_VISIBLE);
        sync_next.hs    = !((int'(x_next) >= HS_START) && (int'(x_next) < HS_END));
        sync_next.vs    = !((int'(y_next) >= VS_START) && (int'(y_next) < VS_END));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div          <= '0;
            VGA_Clk      <= 1'b0;
            DrawX        <= '0;
            DrawY        <= '0;
            sync_q       <= SYNC_IDLE;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            div          <= div_next;
            VGA_Clk      <= (div_next >= DIV_HALF);
            DrawX        <= x_next;
            DrawY        <= y_next;
            sync_q       <= sync_next;
            frame_start  <= pixel_ce && (x_next == '0) && (y_next == '0);
            vblank_start <= pixel_ce && (x_next == '0) && (y_next == V_VIS);
        end
    end

    assign blank = sync_q.blank;
    assign hs    = sync_q.hs;
    assign vs    = sync_q.vs;

    sync_delay #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   ($bits(vga_sync_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk_sys (Clk),
        .rst_b   (Reset_n),
        .en      (pixel_ce),
        .source  (sync_q),
        .delayed (sync_dly)
    );

    assign hs_d    = sync_dly.hs;
    assign vs_d    = sync_dly.vs;
    assign blank_d = sync_dly.blank;

endmodule
